// File: rtl/slot_save_load_sequencer.sv
// ---------------------------------------------------------------------------
// slot_save_load_sequencer
//
// Purpose:
//   Owns the single-port score/sensor slot memory. It serves save requests
//   (copy a WORDS_PER_SLOT-word sensor snapshot into a slot) and load requests
//   (stream a slot back out over a valid/ready interface). It also tracks
//   which slots hold a completed save. Slot numbers follow the menu encoding:
//   0 = NONE, 1..NUM_SLOTS = LOC1..LOCn.
//
// Ports:
//   iVGA_CLK, iRST             clock, synchronous active-high reset
//   save_req/save_slot         save request, held until save_ack
//   save_ack/save_err          one-cycle completion pulse, err = bad slot
//   load_req/load_slot         load request, held until load_ack
//   load_ack/load_err          one-cycle completion pulse, err = bad/empty slot
//   src_idx/src_word           snapshot word select / same-cycle snapshot data
//   out_valid/out_ready        loaded-word handshake
//   out_word/out_idx           loaded word and its index within the slot
//   mem_addr/mem_we/mem_re     memory control (read data one cycle after re)
//   mem_wdata/mem_rdata        memory data
//   slot_valid                 bit k set: slot k+1 holds a completed save
//   busy                       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module slot_save_load_sequencer #(
    parameter int DATA_W         = 32,
    parameter int NUM_SLOTS      = 3,
    parameter int WORDS_PER_SLOT = 4,
    parameter int ADDR_W         = 4
) (
    input  logic                              iVGA_CLK,
    input  logic                              iRST,
    input  logic                              save_req,
    input  logic [31:0]                       save_slot,
    output logic                              save_ack,
    output logic                              save_err,
    input  logic                              load_req,
    input  logic [31:0]                       load_slot,
    output logic                              load_ack,
    output logic                              load_err,
    output logic [$clog2(WORDS_PER_SLOT)-1:0] src_idx,
    input  logic [DATA_W-1:0]                 src_word,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_word,
    output logic [$clog2(WORDS_PER_SLOT)-1:0] out_idx,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic                              mem_we,
    output logic                              mem_re,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic [NUM_SLOTS-1:0]              slot_valid,
    output logic                              busy
);

    localparam int IDX_W = $clog2(WORDS_PER_SLOT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_SLOT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_WR,
        LOAD_RD,
        LOAD_OUT,
        ACK
    } state_t;

    // One-hot slot mask; all-zero when the slot number is out of range,
    // which doubles as the range check.
    function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [31:0] slot);
        logic [NUM_SLOTS-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot == 32'(k + 1)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    // First memory address of a slot; only meaningful for in-range slots.
    function automatic logic [ADDR_W-1:0] slot_base(input logic [31:0] slot);
        logic [31:0] t;
        t = (slot - 32'd1) * 32'(WORDS_PER_SLOT);
        return t[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
        return base + ADDR_W'(idx);
    endfunction

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [ADDR_W-1:0]     r_base;
    logic [NUM_SLOTS-1:0]  r_mask;
    logic [NUM_SLOTS-1:0]  r_slot_valid;
    logic                  r_save_ack;
    logic                  r_save_err;
    logic                  r_load_ack;
    logic                  r_load_err;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_word;
    logic [IDX_W-1:0]      r_out_idx;
    logic                  r_first;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_mem_we;
    logic                  r_mem_re;
    logic [IDX_W-1:0]      r_src_idx;

    logic [NUM_SLOTS-1:0]  w_save_mask;
    logic [NUM_SLOTS-1:0]  w_load_mask;
    logic [ADDR_W-1:0]     w_save_base;
    logic [ADDR_W-1:0]     w_load_base;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_load_ok;

    assign w_save_mask = slot_mask(save_slot);
    assign w_load_mask = slot_mask(load_slot);
    assign w_save_base = slot_base(save_slot);
    assign w_load_base = slot_base(load_slot);
    assign w_idx_nxt   = r_idx + 1'b1;
    assign w_load_ok   = |(w_load_mask & r_slot_valid);

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_base       <= '0;
            r_mask       <= '0;
            r_slot_valid <= '0;
            r_save_ack   <= 1'b0;
            r_save_err   <= 1'b0;
            r_load_ack   <= 1'b0;
            r_load_err   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_out_idx    <= '0;
            r_first      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_src_idx    <= '0;
        end else begin
            // Acks and their error flags are single-cycle pulses.
            r_save_ack <= 1'b0;
            r_save_err <= 1'b0;
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Save wins over load; a pending load simply waits.
                    if (save_req) begin
                        if (|w_save_mask) begin
                            // Invalidate first so an interrupted save never
                            // leaves a half-written slot marked valid.
                            r_slot_valid <= r_slot_valid & ~w_save_mask;
                            r_mask       <= w_save_mask;
                            r_base       <= w_save_base;
                            r_idx        <= '0;
                            r_src_idx    <= '0;
                            r_mem_addr   <= w_save_base;
                            r_mem_we     <= 1'b1;
                            r_state      <= SAVE_WR;
                        end else begin
                            r_save_ack <= 1'b1;
                            r_save_err <= 1'b1;
                            r_state    <= ACK;
                        end
                    end else if (load_req) begin
                        if (w_load_ok) begin
                            r_base     <= w_load_base;
                            r_idx      <= '0;
                            r_mem_addr <= w_load_base;
                            r_mem_re   <= 1'b1;
                            r_state    <= LOAD_RD;
                        end else begin
                            r_load_ack <= 1'b1;
                            r_load_err <= 1'b1;
                            r_state    <= ACK;
                        end
                    end
                end

                SAVE_WR: begin
                    if (r_idx == LAST_IDX) begin
                        r_slot_valid <= r_slot_valid | r_mask;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= '0;
                        r_src_idx    <= '0;
                        r_idx        <= '0;
                        r_save_ack   <= 1'b1;
                        r_state      <= ACK;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_src_idx  <= w_idx_nxt;
                        r_mem_addr <= addr_of(r_base, w_idx_nxt);
                    end
                end

                LOAD_RD: begin
                    // Read data arrives during the first LOAD_OUT cycle.
                    r_mem_re    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_idx;
                    r_first     <= 1'b1;
                    r_state     <= LOAD_OUT;
                end

                LOAD_OUT: begin
                    // Capture the read data once; later cycles of a stall
                    // present the held copy.
                    if (r_first) begin
                        r_out_word <= mem_rdata;
                        r_first    <= 1'b0;
                    end
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_idx      <= '0;
                            r_load_ack <= 1'b1;
                            r_state    <= ACK;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_mem_addr <= addr_of(r_base, w_idx_nxt);
                            r_mem_re   <= 1'b1;
                            r_state    <= LOAD_RD;
                        end
                    end
                end

                ACK: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign save_ack   = r_save_ack;
    assign save_err   = r_save_err;
    assign load_ack   = r_load_ack;
    assign load_err   = r_load_err;
    assign out_valid  = r_out_valid;
    assign out_idx    = r_out_idx;
    // The read data is only valid in the first LOAD_OUT cycle, so it is
    // forwarded straight through then and taken from the holding register
    // afterwards.
    assign out_word   = r_first ? mem_rdata : r_out_word;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_re     = r_mem_re;
    // The snapshot source answers src_idx in the same cycle, so the write
    // data is forwarded rather than registered.
    assign mem_wdata  = r_mem_we ? src_word : '0;
    assign src_idx    = r_src_idx;
    assign slot_valid = r_slot_valid;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_slot_save_load_sequencer.sv
module tb_slot_save_load_sequencer;

    localparam int DATA_W = 32;
    localparam int NUM_SLOTS = 3;
    localparam int WPS = 4;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              iRST;
    logic              save_req;
    logic [31:0]       save_slot;
    logic              save_ack;
    logic              save_err;
    logic              load_req;
    logic [31:0]       load_slot;
    logic              load_ack;
    logic              load_err;
    logic [1:0]        src_idx;
    logic [DATA_W-1:0] src_word;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_word;
    logic [1:0]        out_idx;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        slot_valid;
    logic              busy;

    logic [31:0] src_base;
    logic [DATA_W-1:0] mem [16];

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [1:0] idx; logic [31:0] word; } ow_t;
    typedef struct packed { logic is_load; logic err; } ack_t;

    wr_t  wq[$];
    ow_t  oq[$];
    ack_t aq[$];

    slot_save_load_sequencer #(
        .DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS), .WORDS_PER_SLOT(WPS), .ADDR_W(ADDR_W)
    ) dut (
        .iVGA_CLK(clk), .iRST(iRST),
        .save_req(save_req), .save_slot(save_slot), .save_ack(save_ack), .save_err(save_err),
        .load_req(load_req), .load_slot(load_slot), .load_ack(load_ack), .load_err(load_err),
        .src_idx(src_idx), .src_word(src_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_idx(out_idx),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .slot_valid(slot_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot source: combinational, same cycle.
    assign src_word = src_base + 32'(src_idx);

    // Single-port memory: read data one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_slot_writes(input int slot, input logic [31:0] base);
        wr_t e;
        for (int k = 0; k < WPS; k++) begin
            e.addr = 4'((slot - 1) * WPS + k);
            e.data = base + 32'(k);
            wq.push_back(e);
        end
    endtask

    task automatic push_slot_outs(input logic [31:0] base);
        ow_t e;
        for (int k = 0; k < WPS; k++) begin
            e.idx = 2'(k);
            e.word = base + 32'(k);
            oq.push_back(e);
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
        checks++;
        if (busy !== 1'b0 || slot_valid !== 3'b000) begin
            errors++;
            $display("FAIL reset_state busy=%b slot_valid=%b required 0/000", busy, slot_valid);
        end
        checks++;
        if ({save_ack, save_err, load_ack, load_err, out_valid, mem_we, mem_re} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {save_ack, save_err, load_ack, load_err, out_valid, mem_we, mem_re});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || out_word !== '0 || out_idx !== '0 || src_idx !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h oword=%h oidx=%h sidx=%h required all 0",
                     mem_addr, mem_wdata, out_word, out_idx, src_idx);
        end
    endtask

    task automatic test_save();
        wr_t e;
        ack_t ea;
        int ack_cyc, wcnt;
        src_base = 32'hA0;
        push_slot_writes(2, 32'hA0);
        ea.is_load = 1'b0; ea.err = 1'b0; aq.push_back(ea);
        save_slot = 32'd2;
        save_req = 1'b1;
        ack_cyc = 0; wcnt = 0;
        for (int c = 1; c <= 20 && ack_cyc == 0; c++) begin
            tick();
            if (mem_we === 1'b1) begin
                checks++;
                e = (wq.size() != 0) ? wq.pop_front() : '0;
                if (mem_addr !== e.addr || mem_wdata !== e.data || c != wcnt + 1) begin
                    errors++;
                    $display("FAIL save_write addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                             mem_addr, mem_wdata, c, e.addr, e.data, wcnt + 1);
                end
                wcnt++;
            end
            if (save_ack === 1'b1 || load_ack === 1'b1) begin
                ack_cyc = c;
                save_req = 1'b0;
                checks++;
                ea = aq.pop_front();
                if (save_ack !== 1'b1 || load_ack !== 1'b0 || save_err !== ea.err || c != 5) begin
                    errors++;
                    $display("FAIL save_ack save_ack=%b load_ack=%b err=%b cyc=%0d required 1/0/0 cyc=5",
                             save_ack, load_ack, save_err, c);
                end
            end
        end
        checks++;
        if (ack_cyc == 0 || wcnt != 4) begin
            errors++;
            $display("FAIL save_timeout writes=%0d ack_cyc=%0d required 4 writes and an ack", wcnt, ack_cyc);
            save_req = 1'b0;
        end
        tick();
        checks++;
        if (slot_valid !== 3'b010 || busy !== 1'b0) begin
            errors++;
            $display("FAIL save_slot_valid slot_valid=%b busy=%b required 010/0", slot_valid, busy);
        end
    endtask

    // stall_idx/stall_len: hold out_ready low for stall_len cycles on that word.
    task automatic test_load(input string name, input int stall_idx, input int stall_len);
        ow_t e;
        ack_t ea;
        int ack_cyc, ocnt, stall, re_cnt, last_c;
        push_slot_outs(32'hA0);
        ea.is_load = 1'b1; ea.err = 1'b0; aq.push_back(ea);
        load_slot = 32'd2;
        load_req = 1'b1;
        out_ready = 1'b1;
        ack_cyc = 0; ocnt = 0; stall = 0; re_cnt = 0; last_c = 0;
        for (int c = 1; c <= 60 && ack_cyc == 0; c++) begin
            tick();
            if (mem_re === 1'b1) re_cnt++;
            out_ready = 1'b1;
            if (out_valid === 1'b1 && int'(out_idx) == stall_idx && stall < stall_len) begin
                out_ready = 1'b0;
                stall++;
                checks++;
                if (out_word !== 32'hA1 || mem_re !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_stall out_word=%h mem_re=%b required A1/0", name, out_word, mem_re);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                e = (oq.size() != 0) ? oq.pop_front() : '0;
                if (out_idx !== e.idx || out_word !== e.word ||
                    (stall_len == 0 && c != 2 + 2 * ocnt)) begin
                    errors++;
                    $display("FAIL %s_word idx=%0d word=%h cyc=%0d required idx=%0d word=%h cyc=%0d",
                             name, out_idx, out_word, c, e.idx, e.word, 2 + 2 * ocnt);
                end
                ocnt++;
                last_c = c;
            end
            if (save_ack === 1'b1 || load_ack === 1'b1) begin
                ack_cyc = c;
                load_req = 1'b0;
                checks++;
                ea = aq.pop_front();
                if (load_ack !== 1'b1 || save_ack !== 1'b0 || load_err !== ea.err || c != last_c + 1) begin
                    errors++;
                    $display("FAIL %s_ack load_ack=%b save_ack=%b err=%b cyc=%0d required 1/0/0 cyc=%0d",
                             name, load_ack, save_ack, load_err, c, last_c + 1);
                end
            end
        end
        checks++;
        if (ack_cyc == 0 || ocnt != 4 || re_cnt != 4 || stall != stall_len) begin
            errors++;
            $display("FAIL %s_summary ack_cyc=%0d words=%0d reads=%0d stalls=%0d required ack,4,4,%0d",
                     name, ack_cyc, ocnt, re_cnt, stall, stall_len);
            load_req = 1'b0;
        end
        tick();
    endtask

    task automatic test_errors();
        ack_t ea;
        logic [31:0] slots [4];
        logic        is_load;
        int ack_cyc, act;
        slots[0] = 32'd3; slots[1] = 32'd0; slots[2] = 32'd4; slots[3] = 32'h8000_0002;
        for (int t = 0; t < 4; t++) begin
            is_load = (t == 0);
            ea.is_load = is_load; ea.err = 1'b1; aq.push_back(ea);
            if (is_load) begin load_slot = slots[t]; load_req = 1'b1; end
            else begin save_slot = slots[t]; save_req = 1'b1; end
            ack_cyc = 0; act = 0;
            for (int c = 1; c <= 10 && ack_cyc == 0; c++) begin
                tick();
                if (mem_we === 1'b1 || mem_re === 1'b1 || out_valid === 1'b1) act++;
                if (save_ack === 1'b1 || load_ack === 1'b1) begin
                    ack_cyc = c;
                    load_req = 1'b0;
                    save_req = 1'b0;
                    checks++;
                    ea = aq.pop_front();
                    if (load_ack !== ea.is_load || save_ack !== !ea.is_load ||
                        (ea.is_load ? load_err : save_err) !== 1'b1 || c != 1) begin
                        errors++;
                        $display("FAIL err_ack slot=%h save_ack=%b save_err=%b load_ack=%b load_err=%b cyc=%0d required load=%b err=1 cyc=1",
                                 slots[t], save_ack, save_err, load_ack, load_err, c, ea.is_load);
                    end
                end
            end
            checks++;
            if (ack_cyc == 0 || act != 0) begin
                errors++;
                $display("FAIL err_activity slot=%h ack_cyc=%0d mem_activity=%0d required ack and 0", slots[t], ack_cyc, act);
                load_req = 1'b0;
                save_req = 1'b0;
            end
            tick();
        end
        checks++;
        if (slot_valid !== 3'b010) begin
            errors++;
            $display("FAIL err_slot_valid slot_valid=%b required 010", slot_valid);
        end
    endtask

    task automatic test_simultaneous();
        wr_t e;
        ow_t o;
        ack_t ea;
        int acks, sacks, lacks;
        src_base = 32'hB0;
        push_slot_writes(1, 32'hB0);
        push_slot_outs(32'hA0);
        ea.is_load = 1'b0; ea.err = 1'b0; aq.push_back(ea);
        ea.is_load = 1'b1; ea.err = 1'b0; aq.push_back(ea);
        save_slot = 32'd1; load_slot = 32'd2;
        save_req = 1'b1; load_req = 1'b1;
        out_ready = 1'b1;
        acks = 0; sacks = 0; lacks = 0;
        for (int c = 1; c <= 60 && acks < 2; c++) begin
            tick();
            if (mem_we === 1'b1) begin
                checks++;
                e = (wq.size() != 0) ? wq.pop_front() : '0;
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL sim_write addr=%0d data=%h required addr=%0d data=%h", mem_addr, mem_wdata, e.addr, e.data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                o = (oq.size() != 0) ? oq.pop_front() : '0;
                if (out_idx !== o.idx || out_word !== o.word || sacks != 1) begin
                    errors++;
                    $display("FAIL sim_word idx=%0d word=%h save_acks=%0d required idx=%0d word=%h save_acks=1",
                             out_idx, out_word, sacks, o.idx, o.word);
                end
            end
            if (save_ack === 1'b1 || load_ack === 1'b1) begin
                acks++;
                if (save_ack === 1'b1) begin sacks++; save_req = 1'b0; end
                if (load_ack === 1'b1) begin lacks++; load_req = 1'b0; end
                checks++;
                ea = (aq.size() != 0) ? aq.pop_front() : '0;
                if (load_ack !== ea.is_load || save_ack !== !ea.is_load || save_err !== 1'b0 || load_err !== 1'b0) begin
                    errors++;
                    $display("FAIL sim_ack save_ack=%b load_ack=%b errs=%b%b required load=%b err=0",
                             save_ack, load_ack, save_err, load_err, ea.is_load);
                end
            end
        end
        repeat (4) begin
            tick();
            if (save_ack === 1'b1) sacks++;
            if (load_ack === 1'b1) lacks++;
        end
        checks++;
        if (sacks != 1 || lacks != 1 || slot_valid !== 3'b011 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sim_summary save_acks=%0d load_acks=%0d slot_valid=%b busy=%b required 1/1/011/0",
                     sacks, lacks, slot_valid, busy);
            save_req = 1'b0;
            load_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int ack_cyc, act;
        src_base = 32'hC0;
        save_slot = 32'd1;
        save_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 4'(c - 1) || mem_wdata !== 32'hC0 + 32'(c - 1)) begin
                errors++;
                $display("FAIL rmid_write we=%b addr=%0d data=%h required 1/%0d/%h",
                         mem_we, mem_addr, mem_wdata, c - 1, 32'hC0 + 32'(c - 1));
            end
        end
        iRST = 1'b1;
        save_req = 1'b0;
        tick();
        iRST = 1'b0;
        checks++;
        if (busy !== 1'b0 || slot_valid !== 3'b000 ||
            {save_ack, save_err, load_ack, load_err, out_valid, mem_we, mem_re} !== 7'b0) begin
            errors++;
            $display("FAIL rmid_ctrl busy=%b slot_valid=%b ctrl=%b required 0/000/0000000", busy, slot_valid,
                     {save_ack, save_err, load_ack, load_err, out_valid, mem_we, mem_re});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || out_word !== '0 || out_idx !== '0 || src_idx !== '0) begin
            errors++;
            $display("FAIL rmid_data addr=%h wdata=%h oword=%h oidx=%h sidx=%h required all 0",
                     mem_addr, mem_wdata, out_word, out_idx, src_idx);
        end
        load_slot = 32'd1;
        load_req = 1'b1;
        ack_cyc = 0; act = 0;
        for (int c = 1; c <= 10 && ack_cyc == 0; c++) begin
            tick();
            if (mem_re === 1'b1 || out_valid === 1'b1) act++;
            if (save_ack === 1'b1 || load_ack === 1'b1) begin
                ack_cyc = c;
                load_req = 1'b0;
                checks++;
                if (load_ack !== 1'b1 || load_err !== 1'b1 || act != 0) begin
                    errors++;
                    $display("FAIL rmid_load load_ack=%b load_err=%b activity=%0d required 1/1/0", load_ack, load_err, act);
                end
            end
        end
        checks++;
        if (ack_cyc == 0) begin
            errors++;
            $display("FAIL rmid_timeout no load_ack within 10 cycles");
            load_req = 1'b0;
        end
        tick();
    endtask

    initial begin
        iRST = 1'b1;
        save_req = 1'b0; save_slot = '0;
        load_req = 1'b0; load_slot = '0;
        out_ready = 1'b1;
        src_base = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_save();
        test_load("load", -1, 0);
        test_load("bp", 1, 5);
        test_errors();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
